dragster_spi_responder: RTL and testbench
=========================================

// Module: dragster_spi_responder
// PURPOSE
// - SPI slave model of the Dragster sensor's control port: receives 16-bit register frames, holds an 8-bit register file.
// - Purpose 1: simulation and loopback target for the configurator/quick_spi path.
// - Purpose 2: on-FPGA sensor stand-in, so the video pipeline can run without a real sensor.
// - Frame on wire, both bytes MSB-first: address byte, then data byte.
// - Address byte: bit7 = RNW (1 = read, 0 = write); bits[6:0] = register address.
// PARAMETERS
// - NUM_REGS  default 16  number of 8-bit registers; legal range 1..128.
// - SYNC_STAGES  default 2  synchronizer depth on sclk/ss_n/mosi; legal range 2..3.
// PORTS
// - clk  in  1  system clock; the only clock domain.
// - reset  in  1  synchronous, active-high reset.
// - sclk  in  1  SPI clock from master, async; mode 0 (CPOL=0, CPHA=0).
// - ss_n  in  1  slave select, active low, async.
// - mosi  in  1  master-out data, async.
// - miso  out  1  slave-out data.
// - reg_wr_strobe  out  1  one-cycle pulse when a write commits.
// - reg_wr_addr  out  7  address of the committed write.
// - reg_wr_data  out  8  data of the committed write.
// - regs_flat  out  NUM_REGS*8  register file; reg i = regs_flat[8*i+7 -: 8].
// - frame_error  out  1  one-cycle pulse on a bad frame.
// - error_count  out  8  saturating count of bad frames.
// BEHAVIOUR
// Reset
// - Every output is 0 and every register is 0.
// - FSM goes to IDLE and the bit counter clears.
// - Reset mid-frame aborts the frame: no commit, no error pulse.
// Input sampling and timing
// - sclk, ss_n and mosi each pass through SYNC_STAGES flops.
// - Edges are detected on the synchronized sclk/ss_n.
// - Requirement: sclk frequency <= clk/8.
// FSM states
// - IDLE: wait for ss_n falling. Then bit_cnt = 0 and go to SHIFT.
// - SHIFT, on sclk rising: shift mosi into a 16-bit shift register and increment bit_cnt (5 bits, saturates at 31).
// - SHIFT, ss_n rising with bit_cnt == 16: go to COMMIT.
// - SHIFT, ss_n rising with any other bit_cnt: go to ERROR.
// - COMMIT: lasts one cycle, then IDLE.
//   - Write (RNW = 0) with addr < NUM_REGS: update the register and pulse reg_wr_strobe with addr/data.
//   - Write with addr >= NUM_REGS: dropped silently; no strobe, no error.
//   - Read (RNW = 1): no register change.
// - ERROR: lasts one cycle. Pulse frame_error, increment error_count (saturates at 255), then IDLE.
// Latency and ordering
// - Write latency: reg_wr_strobe and regs_flat update 1 clk after the synchronized ss_n rising edge is detected.
// - ss_n falling while still in COMMIT/ERROR: accepted on the next cycle, so a new frame is never lost.
// - A write to register N is visible in a read of N in the very next frame.
// miso
// - Driven 0 whenever ss_n is high or the FSM is in IDLE.
// CONFIGURATION
// - Macro DRAGSTER_RESPONDER_READBACK_EN.
// - Defined:
//   - Read frames return register data: after bit 8 has been sampled, reg[addr] loads into a tx shift register.
//   - Its MSB is driven on miso and shifted on each sclk falling edge for bits 8..15.
//   - addr >= NUM_REGS returns 8'h00.
//   - miso is 0 during the address byte.
// - Undefined:
//   - miso is tied to 0.
//   - Read frames are still parsed and still counted as valid frames.
// TESTING
// - Write 0x05 <- 0x13 (bytes 0x05, 0x13) -> one reg_wr_strobe, addr=5, data=0x13, regs_flat[47:40]=0x13.
// - Five back-to-back frames (5:0x13, 2:0x32, 3:0x08, 9:0x1F, 1:0xA9) -> five strobes in order, all values held.
// - ss_n rises after 9 bits -> frame_error pulse, error_count=1, regs unchanged; the next good frame commits normally.
// - Write addr 0x40 (>= NUM_REGS) -> no strobe, no error, regs unchanged; 17-bit frame -> frame_error.
// - READBACK_EN: write 3:0x08, then read 0x83 -> miso shifts 0x08 MSB-first in bits 8..15; without the macro, miso stays 0.
// - reset asserted at bit 12 of a write -> no strobe; after release all regs = 0 and error_count = 0.

Source files
------------

// File: rtl/dragster_spi_responder.sv
// Dragster sensor control-port SPI slave (mode 0): 16-bit frames
// {rnw, addr[6:0], data[7:0]} MSB-first into an 8-bit register file.
// Ports: clk/reset (sync, active-high); sclk/ss_n/mosi async SPI in;
//   miso out; reg_wr_strobe/addr/data commit pulse; regs_flat register
//   file (reg i at [8*i+7 -: 8]); frame_error pulse; error_count (sat).
// Build option: define DRAGSTER_RESPONDER_READBACK_EN to return register
//   data on miso during read frames; otherwise miso is tied low.
module dragster_spi_responder #(
    parameter int NUM_REGS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  reg_wr_strobe,
    output logic [6:0]            reg_wr_addr,
    output logic [7:0]            reg_wr_data,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  frame_error,
    output logic [7:0]            error_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, ss_prev_q;
    logic [1:0]             state_q, state_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [15:0]            shift_q, shift_d;
    logic [NUM_REGS*8-1:0]  regs_q, regs_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic [6:0]             wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   ferr_q, ferr_d;
    logic [7:0]             err_cnt_q, err_cnt_d;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, ss_fall, ss_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ss_fall   = ~ss_s & ss_prev_q;
    assign ss_rise   = ss_s & ~ss_prev_q;

    assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    assign ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

`ifdef DRAGSTER_RESPONDER_READBACK_EN
    logic [7:0] tx_q, tx_d;
    logic       miso_q, miso_d;
    logic [7:0] rd_byte;
    logic [6:0] rd_addr;
    logic       sclk_fall;

    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // Address byte completes on the 8th rising edge; mosi_s is its last bit.
    assign rd_addr   = {shift_q[5:0], mosi_s};

    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 7'(i)) rd_byte = regs_q[8*i +: 8];
        end
    end

    always_comb begin
        tx_d = tx_q;
        if (state_q == SHIFT && !ss_rise) begin
            if (sclk_rise && bit_cnt_q == 5'd7) begin
                tx_d = shift_q[6] ? rd_byte : 8'h00;
            end else if (sclk_fall && bit_cnt_q >= 5'd9
                         && bit_cnt_q <= 5'd15) begin
                tx_d = {tx_q[6:0], 1'b0};
            end
        end
        miso_d = (state_q == SHIFT && !ss_s && bit_cnt_q >= 5'd8)
                 ? tx_q[7] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q   <= 8'h00;
            miso_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            miso_q <= miso_d;
        end
    end

    // Gate with the raw select so miso drops as soon as ss_n deasserts.
    assign miso = miso_q & ~ss_n;
`else
    assign miso = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        ferr_d      = 1'b0;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 5'd0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = (bit_cnt_q == 5'd16) ? COMMIT : ERROR;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], mosi_s};
                    if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            COMMIT: begin
                if (!shift_q[15] && int'(shift_q[14:8]) < NUM_REGS) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (shift_q[14:8] == 7'(i)) begin
                            regs_d[8*i +: 8] = shift_q[7:0];
                        end
                    end
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = shift_q[14:8];
                    wr_data_d   = shift_q[7:0];
                end
            end
            default: begin
                ferr_d = 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
        endcase
        // A select arriving during the one-cycle COMMIT/ERROR is not lost.
        if (state_q == COMMIT || state_q == ERROR) begin
            state_d   = ss_fall ? SHIFT : IDLE;
            bit_cnt_d = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 16'h0000;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            wr_data_q   <= 8'h00;
            ferr_q      <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            ferr_q      <= ferr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign reg_wr_strobe = wr_strobe_q;
    assign reg_wr_addr   = wr_addr_q;
    assign reg_wr_data   = wr_data_q;
    assign regs_flat     = regs_q;
    assign frame_error   = ferr_q;
    assign error_count   = err_cnt_q;

endmodule

// File: tb/tb_dragster_spi_responder.sv
// Directed bench for dragster_spi_responder: writes, back-to-back frames,
// short/long frames, out-of-range writes, readback and mid-frame reset.
module tb_dragster_spi_responder;

    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sclk = 1'b0;
    logic          ss_n = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic          reg_wr_strobe;
    logic [6:0]    reg_wr_addr;
    logic [7:0]    reg_wr_data;
    logic [NR*8-1:0] regs_flat;
    logic          frame_error;
    logic [7:0]    error_count;

    dragster_spi_responder #(.NUM_REGS(NR), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .sclk          (sclk),
        .ss_n          (ss_n),
        .mosi          (mosi),
        .miso          (miso),
        .reg_wr_strobe (reg_wr_strobe),
        .reg_wr_addr   (reg_wr_addr),
        .reg_wr_data   (reg_wr_data),
        .regs_flat     (regs_flat),
        .frame_error   (frame_error),
        .error_count   (error_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [14:0] slog[$];
    int ferr_n = 0;
    logic [7:0] exp_regs [NR];
    logic [7:0] rd;
    logic       miso_hi;

    always @(negedge clk) begin
        if (reg_wr_strobe) slog.push_back({reg_wr_addr, reg_wr_data});
        if (frame_error) ferr_n++;
        if (miso) miso_hi = 1'b1;
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [NR*8-1:0] exp_flat();
        logic [NR*8-1:0] f;
        for (int i = 0; i < NR; i++) f[8*i +: 8] = exp_regs[i];
        return f;
    endfunction

    // Sends the low n bits of 'bits' MSB-first; captures miso before the
    // rising edges of bits 8..15.
    task automatic spi_frame(input logic [31:0] bits, input int n,
                             output logic [7:0] r);
        r = 8'h00;
        ss_n = 1'b0;
        clks(8);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            clks(8);
            if ((n - 1 - i) >= 8 && (n - 1 - i) <= 15) r = {r[6:0], miso};
            sclk = 1'b1;
            clks(8);
            sclk = 1'b0;
        end
        clks(4);
        ss_n = 1'b1;
        mosi = 1'b0;
        clks(4);
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        spi_frame({16'h0, 1'b0, a, d}, 16, dummy);
    endtask

    task automatic chk_regs(input string tag);
        chk(tag, regs_flat, exp_flat());
    endtask

    int base;
    int fbase;
    logic [14:0] five [5];

    initial begin
        for (int i = 0; i < NR; i++) exp_regs[i] = 8'h00;
        miso_hi = 1'b0;
        clks(5);
        reset = 1'b0;
        clks(4);
        chk_regs("reset_regs");
        chk("reset_errcnt", error_count, 0);
        chk("reset_miso", miso, 0);
        chk("reset_strobe", reg_wr_strobe, 0);
        chk("reset_ferr", frame_error, 0);

        wr(7'd5, 8'h13);
        clks(12);
        exp_regs[5] = 8'h13;
        chk("w1_count", slog.size(), 1);
        chk("w1_addr", slog[0][14:8], 5);
        chk("w1_data", slog[0][7:0], 8'h13);
        chk("w1_reg5", regs_flat[47:40], 8'h13);

        five[0] = {7'd5, 8'h13};
        five[1] = {7'd2, 8'h32};
        five[2] = {7'd3, 8'h08};
        five[3] = {7'd9, 8'h1F};
        five[4] = {7'd1, 8'hA9};
        base = slog.size();
        for (int k = 0; k < 5; k++) wr(five[k][14:8], five[k][7:0]);
        clks(12);
        chk("b2b_count", slog.size() - base, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("b2b_entry%0d", k), slog[base + k], five[k]);
            exp_regs[five[k][14:8]] = five[k][7:0];
        end
        chk_regs("b2b_regs");

        base = slog.size();
        fbase = ferr_n;
        spi_frame(32'h0000_01AB, 9, rd);
        clks(12);
        chk("short_ferr", ferr_n - fbase, 1);
        chk("short_errcnt", error_count, 1);
        chk("short_nostrobe", slog.size() - base, 0);
        chk_regs("short_regs");
        wr(7'd7, 8'h5A);
        clks(12);
        exp_regs[7] = 8'h5A;
        chk("after_err_count", slog.size() - base, 1);
        chk_regs("after_err_regs");

        base = slog.size();
        fbase = ferr_n;
        wr(7'h40, 8'hEE);
        clks(12);
        chk("oor_nostrobe", slog.size() - base, 0);
        chk("oor_noerr", ferr_n - fbase, 0);
        chk("oor_errcnt", error_count, 1);
        chk_regs("oor_regs");
        spi_frame(32'h0000_0ABC, 17, rd);
        clks(12);
        chk("long_ferr", ferr_n - fbase, 1);
        chk("long_errcnt", error_count, 2);
        chk("long_nostrobe", slog.size() - base, 0);

        miso_hi = 1'b0;
        spi_frame({16'h0, 8'h83, 8'h00}, 16, rd);
        clks(12);
`ifdef DRAGSTER_RESPONDER_READBACK_EN
        chk("read3_data", rd, 8'h08);
        spi_frame({16'h0, 8'hFF, 8'h00}, 16, rd);
        clks(12);
        chk("read_oor_data", rd, 8'h00);
`else
        chk("read3_data", rd, 8'h00);
        chk("read3_miso_low", miso_hi, 1'b0);
`endif
        chk("read_nostrobe", slog.size() - base, 0);
        chk_regs("read_regs");
        chk("read_errcnt", error_count, 2);

        base = slog.size();
        fbase = ferr_n;
        ss_n = 1'b0;
        clks(8);
        for (int i = 15; i > 3; i--) begin
            mosi = (16'h0477 >> i) & 16'h1;
            clks(8);
            sclk = 1'b1;
            clks(8);
            sclk = 1'b0;
        end
        reset = 1'b1;
        ss_n = 1'b1;
        mosi = 1'b0;
        clks(5);
        reset = 1'b0;
        clks(12);
        for (int i = 0; i < NR; i++) exp_regs[i] = 8'h00;
        chk("rst_nostrobe", slog.size() - base, 0);
        chk("rst_noferr", ferr_n - fbase, 0);
        chk_regs("rst_regs");
        chk("rst_errcnt", error_count, 0);

        wr(7'd4, 8'hC3);
        clks(12);
        exp_regs[4] = 8'hC3;
        chk("post_rst_count", slog.size() - base, 1);
        chk_regs("post_rst_regs");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
